uart_fifo_ext: RTL

Parametrised UART data FIFO with storage, status, and a character-timeout detector. It is the next-generation buffer behind the UART TX and RX paths: one instance feeds the transmitter, one collects from the receiver. It generalises the existing FIFO control with a selectable trigger direction, sticky error flags with explicit clear, flush, and an RX idle timeout.

---
 rtl/uart_fifo_pkg.sv | 17 +
 rtl/uart_fifo_ext_if.sv | 38 +++
 rtl/uart_fifo_mem.sv | 23 ++
 rtl/uart_fifo_ext.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/uart_fifo_pkg.sv
// Shared types and defaults for the UART data FIFO (uart_fifo_ext and its storage).
package uart_fifo_pkg;

  typedef enum logic {
    TRIG_RX = 1'b0,
    TRIG_TX = 1'b1
  } trig_mode_e;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_FIFO_DEPTH = 16;
  localparam int unsigned DEF_TO_WIDTH   = 16;

  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/uart_fifo_ext_if.sv
// Bus bundle between a UART FIFO user (master) and the uart_fifo_ext block (slave).
interface uart_fifo_ext_if
  import uart_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned TO_WIDTH   = DEF_TO_WIDTH
);
  localparam int unsigned ADDR_WIDTH = addr_width(FIFO_DEPTH);

  logic                  flush;
  logic                  wr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [ADDR_WIDTH-1:0] trig_level;
  logic                  trig_mode;
  logic                  err_clr;
  logic [TO_WIDTH-1:0]   timeout_cycles;
  logic [ADDR_WIDTH:0]   count;
  logic                  full;
  logic                  empty;
  logic                  overflow;
  logic                  underflow;
  logic                  thr_trig;
  logic                  timeout;

  modport master (
    output flush, wr, wr_data, rd, trig_level, trig_mode, err_clr, timeout_cycles,
    input  rd_data, count, full, empty, overflow, underflow, thr_trig, timeout
  );

  modport slave (
    input  flush, wr, wr_data, rd, trig_level, trig_mode, err_clr, timeout_cycles,
    output rd_data, count, full, empty, overflow, underflow, thr_trig, timeout
  );

endinterface

// File: rtl/uart_fifo_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port, no reset.
module uart_fifo_mem #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [0:FIFO_DEPTH-1];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_fifo_ext.sv
// UART data FIFO with sticky errors, flush, threshold trigger and optional RX idle timeout.
// Define UART_FIFO_TIMEOUT_EN to build the character-timeout counter; otherwise timeout is 0.
module uart_fifo_ext
  import uart_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned TO_WIDTH   = DEF_TO_WIDTH
) (
  input logic            clk,
  input logic            rst,
  uart_fifo_ext_if.slave bus
);

  localparam int unsigned ADDR_WIDTH = addr_width(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(FIFO_DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  thr_q, thr_d;
  logic                  wr_acc, rd_acc, ovf_set, unf_set;
  trig_mode_e            mode;

  assign mode = trig_mode_e'(bus.trig_mode);

  // RX fills toward the level (level 0 behaves as 1); TX drains down to it.
  function automatic logic thr_eval(input logic [ADDR_WIDTH:0]   cnt,
                                    input logic [ADDR_WIDTH-1:0] lvl,
                                    input trig_mode_e            m);
    logic [ADDR_WIDTH:0] lvl_ext;
    lvl_ext = {1'b0, lvl};
    if (m == TRIG_TX) return cnt <= lvl_ext;
    if (lvl == '0) lvl_ext = {{ADDR_WIDTH{1'b0}}, 1'b1};
    return cnt >= lvl_ext;
  endfunction

  always_comb begin
    wr_acc  = bus.wr && (!full_q || bus.rd) && !bus.flush;
    rd_acc  = bus.rd && !empty_q && !bus.flush;
    ovf_set = bus.wr && full_q && !bus.rd && !bus.flush;
    unf_set = bus.rd && empty_q && !bus.flush;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
      count_d = count_q + {{ADDR_WIDTH{1'b0}}, wr_acc} - {{ADDR_WIDTH{1'b0}}, rd_acc};
    end

    full_d  = (count_d == DEPTH_CNT);
    empty_d = (count_d == '0);
    thr_d   = thr_eval(count_d, bus.trig_level, mode);
    // A new error in the clearing cycle keeps its flag set.
    ovf_d   = ovf_set || (ovf_q && !bus.err_clr);
    unf_d   = unf_set || (unf_q && !bus.err_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      thr_q    <= thr_eval('0, bus.trig_level, mode);
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      thr_q    <= thr_d;
    end
  end

  uart_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.wr_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (bus.rd_data)
  );

  assign bus.count     = count_q;
  assign bus.full      = full_q;
  assign bus.empty     = empty_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
  assign bus.thr_trig  = thr_q;

`ifdef UART_FIFO_TIMEOUT_EN
  logic [TO_WIDTH-1:0] to_cnt_q, to_cnt_d;
  logic                timeout_q, timeout_d;

  // Counts idle cycles while holding data; saturates so timeout stays up until activity.
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (bus.flush || wr_acc || rd_acc || empty_q) begin
      to_cnt_d = '0;
    end else if (to_cnt_q < bus.timeout_cycles) begin
      to_cnt_d = to_cnt_q + TO_WIDTH'(1);
    end
    timeout_d = (bus.timeout_cycles != '0) && (to_cnt_d == bus.timeout_cycles);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout = timeout_q;
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^bus.timeout_cycles;
  assign bus.timeout = 1'b0;
`endif

endmodule
